// File: rtl/up_sample.sv
// rtl/up_sample.sv - interpolating upsampler: linear ramp between successive captured samples
module up_sample #(
    parameter int n   = 18,
    parameter int mul = 20
) (
    input  logic                Clk,
    input  logic                nReset,
    input  logic signed [n-1:0] Input,
    output logic signed [n-1:0] Output,
    output logic                Strobe
);

    localparam logic signed [n-1:0] max_pos = {1'b0, {(n-1){1'b1}}};

    logic        [mul-1:0]   count;
    logic signed [n-1:0]     t;
    logic signed [n:0]       d;
    logic signed [n+mul-1:0] a;

    logic                    capture;
    logic signed [n:0]       step;
    logic signed [n+mul-1:0] d_ext;
    logic signed [n-1:0]     a_int;
    logic        [n-1:0]     round_bit;

    // Step is formed one bit wider than the samples so a full-scale swing cannot overflow.
    always_comb begin
        capture   = (count == '0);
        step      = {Input[n-1], Input} - {t[n-1], t};
        d_ext     = d;
        a_int     = a[n+mul-1:mul];
        round_bit = '0;
        round_bit[0] = a[mul-1];
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            count  <= '0;
            t      <= '0;
            d      <= '0;
            a      <= '0;
            Output <= '0;
            Strobe <= 1'b0;
        end else begin
            count <= count + mul'(1);
            if (capture) begin
                t      <= Input;
                d      <= step;
                // Reload from the previous target so the ramp lands exactly on it.
                a      <= {t, {mul{1'b0}}};
                Strobe <= 1'b1;
            end else begin
                a      <= a + d_ext;
                Strobe <= 1'b0;
            end
            if (a_int == max_pos)
                Output <= a_int;
            else
                Output <= a_int + round_bit;
        end
    end

endmodule

// File: tb/tb_up_sample.sv
// tb/tb_up_sample.sv - directed self-checking bench for up_sample
module tb_up_sample;

    logic              Clk = 1'b0;
    logic              nReset;
    logic signed [7:0] Input;
    logic signed [7:0] Input4;
    logic signed [7:0] Output;
    logic signed [7:0] Output4;
    logic              Strobe;
    logic              Strobe4;

    int passed = 0;
    int total  = 0;
    logic signed [7:0] obs [5];

    always #5 Clk = ~Clk;

    up_sample #(.n(8), .mul(2)) dut (
        .Clk    (Clk),
        .nReset (nReset),
        .Input  (Input),
        .Output (Output),
        .Strobe (Strobe)
    );

    up_sample #(.n(8), .mul(4)) dut4 (
        .Clk    (Clk),
        .nReset (nReset),
        .Input  (Input4),
        .Output (Output4),
        .Strobe (Strobe4)
    );

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic do_reset();
        nReset = 1'b0;
        tick();
        tick();
        nReset = 1'b1;
    endtask

    // Capture p on edge 1, x on edge 5; record Output after edges 6..10.
    task automatic run_ramp(input logic signed [7:0] p, input logic signed [7:0] x);
        Input = p;
        do_reset();
        tick();
        Input = x;
        for (int i = 0; i < 4; i++) tick();
        for (int j = 0; j < 5; j++) begin
            tick();
            obs[j] = Output;
        end
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        Input  = 8'sd55;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (Output !== 8'sd0) $display("FAIL reset_output clk%0d: got %0d want 0", i, Output);
            else passed++;
            total++;
            if (Strobe !== 1'b0) $display("FAIL reset_strobe clk%0d: got %b want 0", i, Strobe);
            else passed++;
        end
        nReset = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            logic want;
            tick();
            want = ((i - 1) % 4 == 0);
            total++;
            if (Strobe !== want) $display("FAIL strobe_pace clk%0d: got %b want %b", i, Strobe, want);
            else passed++;
        end
    endtask

    task automatic test_linear_ramp();
        int exp_v [5] = '{0, 10, 20, 30, 40};
        run_ramp(8'sd0, 8'sd40);
        for (int j = 0; j < 5; j++) begin
            total++;
            if (obs[j] !== exp_v[j][7:0]) $display("FAIL linear_ramp[%0d]: got %0d want %0d", j, obs[j], exp_v[j]);
            else passed++;
        end
    endtask

    task automatic test_rounding();
        int exp_p [5] = '{0, 0, 1, 1, 1};
        int exp_n [5] = '{0, 0, 0, -1, -1};
        run_ramp(8'sd0, 8'sd1);
        for (int j = 0; j < 5; j++) begin
            total++;
            if (obs[j] !== exp_p[j][7:0]) $display("FAIL round_pos[%0d]: got %0d want %0d", j, obs[j], exp_p[j]);
            else passed++;
        end
        run_ramp(8'sd0, -8'sd1);
        for (int j = 0; j < 5; j++) begin
            total++;
            if (obs[j] !== exp_n[j][7:0]) $display("FAIL round_neg[%0d]: got %0d want %0d", j, obs[j], exp_n[j]);
            else passed++;
        end
    endtask

    task automatic test_full_scale();
        int exp_s [5] = '{127, 63, 0, -64, -128};
        int exp_m [5] = '{126, 126, 127, 127, 127};
        run_ramp(8'sd127, -8'sd128);
        for (int j = 0; j < 5; j++) begin
            total++;
            if (obs[j] !== exp_s[j][7:0]) $display("FAIL full_swing[%0d]: got %0d want %0d", j, obs[j], exp_s[j]);
            else passed++;
        end
        run_ramp(8'sd126, 8'sd127);
        for (int j = 0; j < 5; j++) begin
            total++;
            if (obs[j] !== exp_m[j][7:0]) $display("FAIL near_max[%0d]: got %0d want %0d", j, obs[j], exp_m[j]);
            else passed++;
        end
        for (int j = 0; j < 6; j++) begin
            tick();
            total++;
            if (Output !== 8'sd127) $display("FAIL max_hold[%0d]: got %0d want 127", j, Output);
            else passed++;
        end
    endtask

    task automatic test_mid_reset();
        Input = 8'sd0;
        do_reset();
        tick();
        Input = 8'sd40;
        for (int i = 0; i < 4; i++) tick();
        tick();
        tick();
        total++;
        if (Output !== 8'sd10) $display("FAIL mid_pre: got %0d want 10", Output);
        else passed++;
        nReset = 1'b0;
        #1;
        total++;
        if (Output !== 8'sd0) $display("FAIL mid_async_output: got %0d want 0", Output);
        else passed++;
        total++;
        if (dut.a !== '0 || dut.count !== '0 || dut.t !== '0 || dut.d !== '0)
            $display("FAIL mid_async_state: got a=%0d count=%0d t=%0d d=%0d want all 0", dut.a, dut.count, dut.t, dut.d);
        else passed++;
        @(negedge Clk);
        nReset = 1'b1;
        tick();
        total++;
        if (Strobe !== 1'b1) $display("FAIL mid_recapture_strobe: got %b want 1", Strobe);
        else passed++;
        tick();
        total++;
        if (Strobe !== 1'b0 || Output !== 8'sd0) $display("FAIL mid_after1: got strobe=%b out=%0d want 0/0", Strobe, Output);
        else passed++;
        tick();
        total++;
        if (Output !== 8'sd10) $display("FAIL mid_ramp_restart: got %0d want 10", Output);
        else passed++;
    endtask

    task automatic test_glitch();
        int exp_v [5] = '{0, 10, 20, 30, 40};
        Input = 8'sd0;
        do_reset();
        tick();
        Input = 8'sd77;   tick();
        Input = -8'sd50;  tick();
        Input = 8'sd99;   tick();
        Input = 8'sd40;   tick();
        Input = -8'sd128; tick(); obs[0] = Output;
        Input = 8'sd13;   tick(); obs[1] = Output;
        Input = 8'sd127;  tick(); obs[2] = Output;
        Input = 8'sd40;   tick(); obs[3] = Output;
        tick(); obs[4] = Output;
        for (int j = 0; j < 5; j++) begin
            total++;
            if (obs[j] !== exp_v[j][7:0]) $display("FAIL glitch[%0d]: got %0d want %0d", j, obs[j], exp_v[j]);
            else passed++;
        end
    endtask

    task automatic test_round_trip();
        Input4 = 8'sd100;
        do_reset();
        for (int i = 0; i < 17; i++) tick();
        total++;
        if (Output4 !== 8'sd94) $display("FAIL trip_pre: got %0d want 94", Output4);
        else passed++;
        for (int i = 0; i < 21; i++) begin
            tick();
            total++;
            if (Output4 !== 8'sd100) $display("FAIL trip_settle[%0d]: got %0d want 100", i, Output4);
            else passed++;
        end
    endtask

    initial begin
        nReset = 1'b0;
        Input  = '0;
        Input4 = 8'sd100;
        test_reset();
        test_linear_ramp();
        test_rounding();
        test_full_scale();
        test_mid_reset();
        test_glitch();
        test_round_trip();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
